io_spi_xfer_seq: RTL and testbench

//  Bus-master sequencer upstream of the SPI controller. Accepts one SPI transaction request,

---
 rtl/io_spi_xfer_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_io_spi_xfer_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_spi_xfer_seq.sv
// Purpose: sequences one SPI transaction onto the controller's dma_io register bus (program, EXEC, poll, buffer I/O).
// Latency: first register write 1 cycle after accept; EXEC polled every POLL_GAP+2 cycles until bit0 clears.
// Backpressure: req_ready only in IDLE; wd consumed only in W_BUF; rd_data held until rd_ready. Option: IO_SPI_SEQ_TIMEOUT_EN.
module io_spi_xfer_seq #(
    parameter int POLL_GAP    = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic        req_csn,
    input  logic [2:0]  req_cmd_len,
    input  logic [31:0] req_cmd_val,
    input  logic [4:0]  req_dat_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic        dma_io_we,
    output logic [13:0] dma_io_wadr,
    output logic [31:0] dma_io_wdata,
    output logic        dma_io_radr_en,
    output logic [13:0] dma_io_radr,
    input  logic [31:0] dma_io_rdata
);
    localparam logic [13:0] ADR_EXEC = 14'h3C80;
    localparam logic [13:0] ADR_COML = 14'h3C83;
    localparam logic [13:0] ADR_COMV = 14'h3C84;
    localparam logic [13:0] ADR_DATL = 14'h3C85;
    localparam logic [13:0] ADR_BUF  = 14'h3C88;
    localparam logic [3:0]  GAP_LAST = 4'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_COML, S_W_COMV, S_W_DATL, S_W_BUF, S_W_EXEC, S_POLL_RD,
        S_POLL_CHK, S_POLL_GAP, S_R_ADR, S_R_CAP, S_R_OUT, S_W_ABORT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic        csn_q, csn_d;
    logic [2:0]  cmd_len_q, cmd_len_d;
    logic [31:0] cmd_val_q, cmd_val_d;
    logic [4:0]  dat_len_q, dat_len_d;
    logic [2:0]  nw_q, nw_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [31:0] rd_dat_q, rd_dat_d;
    logic [4:0]  dl_clamp;
    logic        last_word;
    logic        tmo_hit;

    assign dl_clamp  = (req_dat_len > 5'd16) ? 5'd16 : req_dat_len;
    assign last_word = ({1'b0, idx_q} == (nw_q - 3'd1));
    assign rd_data   = rd_dat_q;

`ifdef IO_SPI_SEQ_TIMEOUT_EN
    logic        in_poll;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    assign in_poll = (state_q == S_POLL_RD) || (state_q == S_POLL_CHK) || (state_q == S_POLL_GAP);
    assign tmo_hit = in_poll && (tmo_q == 16'(TIMEOUT_CYC));
    assign err     = (state_q == S_DONE) && err_q;

    // Count poll-phase cycles since EXEC was written and remember an abort until DONE.
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == S_W_EXEC) begin
            tmo_d = '0;
        end else if (in_poll && !tmo_hit) begin
            tmo_d = tmo_q + 16'd1;
        end
        if (state_q == S_IDLE) begin
            err_d = 1'b0;
        end else if (state_q == S_W_ABORT) begin
            err_d = 1'b1;
        end
    end

    // Timeout counter and abort flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state, latched request fields and bus strobes; one bus access per state at most.
    always_comb begin
        state_d        = state_q;
        rw_d           = rw_q;
        csn_d          = csn_q;
        cmd_len_d      = cmd_len_q;
        cmd_val_d      = cmd_val_q;
        dat_len_d      = dat_len_q;
        nw_d           = nw_q;
        idx_d          = idx_q;
        gap_d          = gap_q;
        rd_dat_d       = rd_dat_q;
        req_ready      = 1'b0;
        wd_ready       = 1'b0;
        rd_valid       = 1'b0;
        done           = 1'b0;
        dma_io_we      = 1'b0;
        dma_io_wadr    = '0;
        dma_io_wdata   = '0;
        dma_io_radr_en = 1'b0;
        dma_io_radr    = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rw_d      = req_rw;
                    csn_d     = req_csn;
                    cmd_len_d = req_cmd_len;
                    cmd_val_d = req_cmd_val;
                    dat_len_d = dl_clamp;
                    nw_d      = dl_clamp[4:2] + {2'b00, |dl_clamp[1:0]};
                    idx_d     = '0;
                    state_d   = S_W_COML;
                end
            end
            S_W_COML: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = ADR_COML;
                dma_io_wdata = {29'd0, cmd_len_q};
                state_d      = S_W_COMV;
            end
            S_W_COMV: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = ADR_COMV;
                dma_io_wdata = cmd_val_q;
                state_d      = S_W_DATL;
            end
            S_W_DATL: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = ADR_DATL;
                dma_io_wdata = {27'd0, dat_len_q};
                state_d      = (rw_q && (nw_q != 3'd0)) ? S_W_BUF : S_W_EXEC;
            end
            S_W_BUF: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    dma_io_we    = 1'b1;
                    dma_io_wadr  = ADR_BUF + {12'd0, idx_q};
                    dma_io_wdata = wd_data;
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = S_W_EXEC;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_W_EXEC: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = ADR_EXEC;
                dma_io_wdata = {28'd0, csn_q, 1'b0, rw_q, 1'b1};
                state_d      = S_POLL_RD;
            end
            S_POLL_RD: begin
                dma_io_radr_en = 1'b1;
                dma_io_radr    = ADR_EXEC;
                state_d        = tmo_hit ? S_W_ABORT : S_POLL_CHK;
            end
            S_POLL_CHK: begin
                // A busy read right after EXEC just means the controller has not picked it up yet.
                if (!dma_io_rdata[0]) begin
                    state_d = (!rw_q && (nw_q != 3'd0)) ? S_R_ADR : S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_W_ABORT;
                end else if (POLL_GAP == 0) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_d   = '0;
                    state_d = S_POLL_GAP;
                end
            end
            S_POLL_GAP: begin
                if (tmo_hit) begin
                    state_d = S_W_ABORT;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_R_ADR: begin
                dma_io_radr_en = 1'b1;
                dma_io_radr    = ADR_BUF + {12'd0, idx_q};
                state_d        = S_R_CAP;
            end
            S_R_CAP: begin
                rd_dat_d = dma_io_rdata;
                state_d  = S_R_OUT;
            end
            S_R_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_R_ADR;
                    end
                end
            end
            S_W_ABORT: begin
                dma_io_we    = 1'b1;
                dma_io_wadr  = ADR_EXEC;
                dma_io_wdata = 32'd0;
                state_d      = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rw_q      <= 1'b0;
            csn_q     <= 1'b0;
            cmd_len_q <= '0;
            cmd_val_q <= '0;
            dat_len_q <= '0;
            nw_q      <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            rd_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            csn_q     <= csn_d;
            cmd_len_q <= cmd_len_d;
            cmd_val_q <= cmd_val_d;
            dat_len_q <= dat_len_d;
            nw_q      <= nw_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            rd_dat_q  <= rd_dat_d;
        end
    end
endmodule

// File: tb/tb_io_spi_xfer_seq.sv
// Bench for io_spi_xfer_seq: directed steps with randomized fields against a transaction-level model.
// The model is a list of expected register writes / read words / poll timing per request.
// A fake controller answers dma_io reads: EXEC busy for N polls, BUF words from a random table.
module tb_io_spi_xfer_seq;
    localparam int POLL_GAP = 4;
`ifdef IO_SPI_SEQ_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
`else
    localparam int TIMEOUT_CYC = 65535;
`endif
    localparam logic [13:0] A_EXEC = 14'h3C80;
    localparam logic [13:0] A_COML = 14'h3C83;
    localparam logic [13:0] A_COMV = 14'h3C84;
    localparam logic [13:0] A_DATL = 14'h3C85;
    localparam logic [13:0] A_BUF  = 14'h3C88;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_rw, req_csn;
    logic [2:0]  req_cmd_len;
    logic [31:0] req_cmd_val;
    logic [4:0]  req_dat_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        done, err;
    logic        dma_io_we, dma_io_radr_en;
    logic [13:0] dma_io_wadr, dma_io_radr;
    logic [31:0] dma_io_wdata, dma_io_rdata;

    io_spi_xfer_seq #(.POLL_GAP(POLL_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_csn(req_csn),
        .req_cmd_len(req_cmd_len), .req_cmd_val(req_cmd_val), .req_dat_len(req_dat_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
        .dma_io_radr_en(dma_io_radr_en), .dma_io_radr(dma_io_radr), .dma_io_rdata(dma_io_rdata)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Observed history (written only by the monitor).
    logic [45:0] wr_log[$];
    int          wr_cyc[$];
    logic [31:0] rd_log[$];
    int          poll_cyc[$];
    int poll_cnt = 0, wd_cnt = 0, stall_seen = 0, done_cnt = 0, err_cnt = 0, accept_cyc = -1;
    int excl_viol = 0, hold_viol = 0, bp_radr_viol = 0;
    logic        prev_stall;
    logic [31:0] prev_rd;

    // Stimulus knobs (written only by the main sequence).
    logic [31:0] wd_arr[5];
    logic [31:0] rd_src[4];
    int wd_base = 0, wd_num = 0, poll_base = 0, busy_n = 0, stall_base = 0, stall_target = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d, required < 100000)", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor and fake controller: log bus activity, answer reads, check per-cycle rules.
    initial begin
        logic [31:0] resp;
        dma_io_rdata = '0;
        prev_stall   = 1'b0;
        prev_rd      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (dma_io_we && dma_io_radr_en) excl_viol++;
                if (dma_io_we) begin
                    wr_log.push_back({dma_io_wadr, dma_io_wdata});
                    wr_cyc.push_back(cyc);
                end
                if (dma_io_radr_en) begin
                    if (rd_valid) bp_radr_viol++;
                    resp = $urandom;
                    if (dma_io_radr == A_EXEC) begin
                        resp[0] = ((poll_cnt - poll_base) < busy_n);
                        poll_cnt++;
                        poll_cyc.push_back(cyc);
                    end else if (dma_io_radr >= A_BUF && dma_io_radr <= A_BUF + 14'd3) begin
                        resp = rd_src[2'(dma_io_radr - A_BUF)];
                    end
                    dma_io_rdata = resp;
                end
                if (prev_stall && !(rd_valid && rd_data === prev_rd)) hold_viol++;
                if (rd_valid && !rd_ready) stall_seen++;
                if (rd_valid && rd_ready) rd_log.push_back(rd_data);
                if (wd_valid && wd_ready) wd_cnt++;
                if (req_valid && req_ready) accept_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    if (err) err_cnt++;
                end
                prev_stall = rd_valid && !rd_ready;
                prev_rd    = rd_data;
            end
        end
    end

    // Read-data consumer: forced stall window, otherwise random rd_ready.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ((stall_seen - stall_base) < stall_target) rd_ready = 1'b0;
            else rd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Write-data source: offers wd_arr words in order with random bubbles.
    initial begin
        wd_valid = 1'b0;
        wd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((wd_cnt - wd_base) < wd_num && $urandom_range(0, 3) != 0) begin
                wd_valid = 1'b1;
                wd_data  = wd_arr[wd_cnt - wd_base];
            end else begin
                wd_valid = 1'b0;
                wd_data  = $urandom;
            end
        end
    end

    task automatic send_req(input bit rw, input bit csn, input logic [2:0] cl, input logic [31:0] cv,
                            input logic [4:0] dl, input string tag);
        int n;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_rw = rw; req_csn = csn;
        req_cmd_len = cl; req_cmd_val = cv; req_dat_len = dl;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        check({tag, "_accept"}, req_ready, 1'b1);
        @(posedge clk);
        #1;
        // Scramble request fields after accept: the DUT must use its latched copy.
        req_valid = 1'b0; req_rw = 1'($urandom); req_csn = 1'($urandom);
        req_cmd_len = 3'($urandom); req_cmd_val = $urandom; req_dat_len = 5'($urandom);
    endtask

    task automatic run_txn(input bit rw, input bit csn, input logic [2:0] cl, input logic [31:0] cv,
                           input logic [4:0] dl_in, input int busy, input int stall,
                           input bit fixed_wd, input bit expect_to, input string tag);
        logic [45:0] exp_wr[$];
        logic [31:0] exp_rd[$];
        int dl, nw, n, wb, rb, pb, db, eb;
        bit hit;
        dl = (dl_in > 5'd16) ? 16 : int'(dl_in);
        nw = (dl + 3) / 4;
        if (!fixed_wd) for (int k = 0; k < 4; k++) wd_arr[k] = $urandom;
        wd_arr[4] = $urandom;
        for (int k = 0; k < 4; k++) rd_src[k] = $urandom;
        exp_wr.push_back({A_COML, 29'd0, cl});
        exp_wr.push_back({A_COMV, cv});
        exp_wr.push_back({A_DATL, 32'(dl)});
        if (rw) for (int k = 0; k < nw; k++) exp_wr.push_back({A_BUF + 14'(k), wd_arr[k]});
        exp_wr.push_back({A_EXEC, 28'd0, csn, 1'b0, rw, 1'b1});
        if (expect_to) exp_wr.push_back({A_EXEC, 32'd0});
        if (!rw && !expect_to) for (int k = 0; k < nw; k++) exp_rd.push_back(rd_src[k]);
        wb = wr_log.size(); rb = rd_log.size(); pb = poll_cnt; db = done_cnt; eb = err_cnt;
        poll_base = poll_cnt; busy_n = busy;
        wd_base = wd_cnt; wd_num = rw ? nw + 1 : 1;
        stall_base = stall_seen; stall_target = stall;
        send_req(rw, csn, cl, cv, dl_in, tag);
        hit = 0; n = 0;
        while (!hit && n < 3000) begin
            @(negedge clk);
            hit = done;
            n++;
        end
        check({tag, "_done_seen"}, hit, 1'b1);
        check({tag, "_err_with_done"}, err, expect_to);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle_ready"}, req_ready, 1'b1);
        check({tag, "_wr_count"}, wr_log.size() - wb, exp_wr.size());
        for (int k = 0; k < exp_wr.size() && wb + k < wr_log.size(); k++)
            check($sformatf("%s_wr%0d", tag, k), wr_log[wb + k], exp_wr[k]);
        if (wr_cyc.size() > wb) check({tag, "_latency"}, wr_cyc[wb] - accept_cyc, 1);
        check({tag, "_rd_count"}, rd_log.size() - rb, exp_rd.size());
        for (int k = 0; k < exp_rd.size() && rb + k < rd_log.size(); k++)
            check($sformatf("%s_rd%0d", tag, k), rd_log[rb + k], exp_rd[k]);
        if (!expect_to) begin
            check({tag, "_polls"}, poll_cnt - pb, busy + 1);
            for (int k = pb + 1; k < poll_cnt; k++)
                check($sformatf("%s_poll_gap%0d", tag, k - pb), poll_cyc[k] - poll_cyc[k - 1], POLL_GAP + 2);
        end
        check({tag, "_wd_consumed"}, wd_cnt - wd_base, rw ? nw : 0);
        check({tag, "_done_count"}, done_cnt - db, 1);
        check({tag, "_err_count"}, err_cnt - eb, expect_to);
        if (stall > 0) check({tag, "_stall_held"}, (stall_seen - stall_base) >= stall, 1'b1);
        wd_num = 0; stall_target = 0;
    endtask

    initial begin
        int n;
        bit hit;
        int wb;
        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_csn = 1'b0;
        req_cmd_len = '0; req_cmd_val = '0; req_dat_len = '0;
        for (int k = 0; k < 5; k++) wd_arr[k] = '0;
        for (int k = 0; k < 4; k++) rd_src[k] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_outputs", {wd_ready, rd_valid, done, err, dma_io_we, dma_io_radr_en}, 6'd0);
        check("rst_buses", {dma_io_wadr, dma_io_wdata, dma_io_radr, rd_data}, 92'd0);

        // Write: two data words, EXEC busy twice.
        wd_arr[0] = 32'h11223344; wd_arr[1] = 32'h00000055;
        run_txn(1'b1, 1'b0, 3'd1, 32'h58, 5'd5, 2, 0, 1'b1, 1'b0, "t1_write");
        // Read: EXEC returns 1,1,0 then two buffer words.
        run_txn(1'b0, 1'b0, 3'd2, $urandom, 5'd8, 2, 0, 1'b0, 1'b0, "t2_read");
        // Read with 20 cycles of rd_ready low.
        run_txn(1'b0, 1'($urandom), 3'd3, $urandom, 5'd12, 1, 20, 1'b0, 1'b0, "t3_backpressure");
        // Zero-length in both directions, then oversize length with csn=1.
        run_txn(1'b1, 1'b0, 3'd4, $urandom, 5'd0, 0, 0, 1'b0, 1'b0, "t4_wr_len0");
        run_txn(1'b0, 1'b1, 3'd1, $urandom, 5'd0, 1, 0, 1'b0, 1'b0, "t4_rd_len0");
        run_txn(1'b1, 1'b1, 3'd4, $urandom, 5'd20, 0, 0, 1'b0, 1'b0, "t4_len20");

        // Reset while waiting in the write-buffer phase.
        wb = wr_log.size();
        wd_base = wd_cnt; wd_num = 0;
        send_req(1'b1, 1'b0, 3'd1, 32'hA5, 5'd16, "t5");
        hit = 0; n = 0;
        while (!hit && n < 50) begin
            @(negedge clk);
            hit = wd_ready;
            n++;
        end
        check("t5_buf_phase", hit, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_strobes", {dma_io_we, dma_io_radr_en, wd_ready, rd_valid, done}, 5'd0);
        check("t5_req_ready", req_ready, 1'b1);
        check("t5_no_abort_write", wr_log.size() - wb, 3);
        run_txn(1'b1, 1'b0, 3'd2, $urandom, 5'd7, 1, 0, 1'b0, 1'b0, "t5_after");

        // Random transactions.
        for (int i = 0; i < 12; i++)
            run_txn(1'($urandom), 1'($urandom), 3'($urandom_range(1, 4)), $urandom,
                    5'($urandom_range(0, 20)), $urandom_range(0, 3), 0, 1'b0, 1'b0,
                    $sformatf("rnd%0d", i));

`ifdef IO_SPI_SEQ_TIMEOUT_EN
        run_txn(1'b0, 1'b0, 3'd1, $urandom, 5'd8, 100000, 0, 1'b0, 1'b1, "t6_timeout");
`endif

        check("strobe_exclusive", excl_viol, 0);
        check("rd_hold_stable", hold_viol, 0);
        check("no_radr_while_rd_valid", bp_radr_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
